// File: rtl/fifo_wr_packer.sv
// Write-domain front end for the async FIFO: packs IN_WIDTH-bit valid/ready beats
// into DATA_WIDTH-bit words and hands them to the FIFO under its full flag.
module fifo_wr_packer #(
  parameter int unsigned         IN_WIDTH   = 4,
  parameter int unsigned         DATA_WIDTH = 8,
  parameter logic [IN_WIDTH-1:0] PAD_VALUE  = '0,
  parameter int unsigned         CNT_WIDTH  = 16
) (
  input  logic                  wr_clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [IN_WIDTH-1:0]   s_data,
  input  logic                  s_last,
  input  logic                  fifo_full,
  output logic                  fifo_wr_en,
  output logic [DATA_WIDTH-1:0] fifo_data,
  output logic [CNT_WIDTH-1:0]  word_count,
  output logic                  busy
);

  localparam int unsigned       RATIO     = DATA_WIDTH / IN_WIDTH;
  localparam int unsigned       LANE_W    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);

  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] word_c;
  logic [DATA_WIDTH-1:0] acc_upd_c;
  logic [LANE_W-1:0]     lane;
  logic                  out_valid;
  logic                  accept_c;
  logic                  complete_c;

  // The held word drains the same cycle the FIFO has room, so the input never stalls while it can.
  assign fifo_wr_en = out_valid && !fifo_full;
  assign s_ready    = !out_valid || !fifo_full;
  assign busy       = (lane != '0) || out_valid;
  assign accept_c   = s_valid && s_ready;
  assign complete_c = accept_c && ((lane == LAST_LANE) || s_last);

  // Completed word: filled lanes from acc, current lane from s_data, the rest padded.
  always_comb begin
    word_c    = '0;
    acc_upd_c = acc;
    for (int unsigned i = 0; i < RATIO; i++) begin
      if (LANE_W'(i) < lane) begin
        word_c[i*IN_WIDTH +: IN_WIDTH] = acc[i*IN_WIDTH +: IN_WIDTH];
      end else if (LANE_W'(i) == lane) begin
        word_c[i*IN_WIDTH +: IN_WIDTH]    = s_data;
        acc_upd_c[i*IN_WIDTH +: IN_WIDTH] = s_data;
      end else begin
        word_c[i*IN_WIDTH +: IN_WIDTH] = PAD_VALUE;
      end
    end
  end

  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) begin
      acc        <= '0;
      lane       <= '0;
      out_valid  <= 1'b0;
      fifo_data  <= '0;
      word_count <= '0;
    end else begin
      if (fifo_wr_en) begin
        word_count <= word_count + CNT_WIDTH'(1);
      end
      if (complete_c) begin
        // A completing beat is only accepted when the out register is empty or draining.
        fifo_data <= word_c;
        out_valid <= 1'b1;
        acc       <= '0;
        lane      <= '0;
      end else begin
        if (fifo_wr_en) begin
          out_valid <= 1'b0;
        end
        if (accept_c) begin
          acc  <= acc_upd_c;
          lane <= lane + LANE_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_packer.sv
// Directed and random bench for fifo_wr_packer; packed words are predicted at
// beat acceptance and compared in order whenever the FIFO write strobe fires.
module tb_fifo_wr_packer;

  localparam int unsigned IN_W  = 4;
  localparam int unsigned DW    = 8;
  localparam int unsigned CW    = 16;
  localparam int unsigned RATIO = DW / IN_W;
  localparam logic [IN_W-1:0] PAD = '0;

  logic            wr_clk = 1'b0;
  logic            rst    = 1'b1;
  logic            s_valid = 1'b0;
  logic            s_ready;
  logic [IN_W-1:0] s_data = '0;
  logic            s_last = 1'b0;
  logic            fifo_full = 1'b0;
  logic            fifo_wr_en;
  logic [DW-1:0]   fifo_data;
  logic [CW-1:0]   word_count;
  logic            busy;

  int errors = 0;
  int checks = 0;
  int writes = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] model_acc = '0;
  int            model_lane = 0;

  fifo_wr_packer #(.IN_WIDTH(IN_W), .DATA_WIDTH(DW), .PAD_VALUE(PAD), .CNT_WIDTH(CW)) dut (
    .wr_clk(wr_clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_data(fifo_data),
    .word_count(word_count), .busy(busy)
  );

  always #5 wr_clk = ~wr_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every FIFO write must match the oldest predicted word and never coincide with full.
  always @(negedge wr_clk) begin
    if (!rst) begin
      check("wr_en_while_full", 32'(fifo_wr_en && fifo_full), 32'd0);
      if (fifo_wr_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL unexpected_write: observed=%0h expected=none", fifo_data);
        end else begin
          check("word", 32'(fifo_data), 32'(exp_q.pop_front()));
        end
        writes++;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge wr_clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_valid = 1'b0;
    s_last = 1'b0;
    cyc(2);
    rst = 1'b0;
    model_acc = '0;
    model_lane = 0;
    exp_q.delete();
    writes = 0;
    #1;
  endtask

  // Offer one beat until accepted; predict the packed word on a completion.
  task automatic beat(input logic [IN_W-1:0] d, input logic last, input bit must_ready);
    logic [DW-1:0] w;
    int n;
    n = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    @(negedge wr_clk);
    if (must_ready) check("s_ready_stream", 32'(s_ready), 32'd1);
    while (!s_ready && n < 1000) begin
      @(negedge wr_clk);
      n++;
    end
    if (!s_ready) begin
      checks++;
      errors++;
      $error("FAIL beat_timeout: observed=s_ready 0 expected=s_ready 1");
    end else begin
      w = model_acc;
      w[model_lane*IN_W +: IN_W] = d;
      if (model_lane == RATIO - 1 || last) begin
        for (int i = model_lane + 1; i < RATIO; i++) w[i*IN_W +: IN_W] = PAD;
        exp_q.push_back(w);
        model_acc = '0;
        model_lane = 0;
      end else begin
        model_acc = w;
        model_lane++;
      end
    end
    @(posedge wr_clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  initial begin
    logic [CW-1:0] wc_base;
    int  wr_base;
    int  n;
    bit  done;

    // Reset state
    do_reset();
    check("rst_wr_en", 32'(fifo_wr_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_s_ready", 32'(s_ready), 32'd1);
    check("rst_word_count", 32'(word_count), 32'd0);
    check("rst_fifo_data", 32'(fifo_data), 32'd0);

    // Two beats form one word, written the following cycle
    beat(4'hA, 1'b0, 1'b1);
    beat(4'hB, 1'b0, 1'b1);
    check("t1_wr_en", 32'(fifo_wr_en), 32'd1);
    check("t1_data", 32'(fifo_data), 32'hBA);
    check("t1_count_before", 32'(word_count), 32'd0);
    cyc(1);
    check("t1_count_after", 32'(word_count), 32'd1);
    check("t1_wr_en_off", 32'(fifo_wr_en), 32'd0);

    // s_last flush with padding
    beat(4'h5, 1'b1, 1'b1);
    check("t2_wr_en", 32'(fifo_wr_en), 32'd1);
    check("t2_data", 32'(fifo_data), 32'h05);
    cyc(1);
    check("t2_busy", 32'(busy), 32'd0);
    check("t2_count", 32'(word_count), 32'd2);
    check("t2_wr_en_off", 32'(fifo_wr_en), 32'd0);

    // Held word under a full FIFO
    fifo_full = 1'b1;
    beat(4'h1, 1'b0, 1'b1);
    beat(4'h2, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge wr_clk);
      check("t3_wr_en_held", 32'(fifo_wr_en), 32'd0);
      check("t3_s_ready_held", 32'(s_ready), 32'd0);
      check("t3_data_held", 32'(fifo_data), 32'h21);
      check("t3_busy_held", 32'(busy), 32'd1);
      @(posedge wr_clk);
      #1;
    end
    check("t3_count_held", 32'(word_count), 32'd2);
    fifo_full = 1'b0;
    #1;
    check("t3_wr_en_release", 32'(fifo_wr_en), 32'd1);
    cyc(1);
    check("t3_count_after", 32'(word_count), 32'd3);

    // Full-throughput stream from a fresh reset
    do_reset();
    for (int i = 1; i <= 8; i++) beat(IN_W'(i), 1'b0, 1'b1);
    check("t4_writes_so_far", 32'(writes), 32'd3);
    check("t4_last_wr_en", 32'(fifo_wr_en), 32'd1);
    check("t4_last_data", 32'(fifo_data), 32'h87);
    cyc(2);
    check("t4_count", 32'(word_count), 32'd4);
    check("t4_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset discards a partial word
    beat(4'h3, 1'b0, 1'b1);
    check("t5_busy_partial", 32'(busy), 32'd1);
    do_reset();
    check("t5_busy_cleared", 32'(busy), 32'd0);
    check("t5_count_cleared", 32'(word_count), 32'd0);
    beat(4'h1, 1'b0, 1'b1);
    beat(4'h2, 1'b0, 1'b1);
    check("t5_data", 32'(fifo_data), 32'h21);
    cyc(3);
    check("t5_count", 32'(word_count), 32'd1);
    check("t5_writes", 32'(writes), 32'd1);
    check("t5_queue_empty", 32'(exp_q.size()), 32'd0);

    // Random backpressure with random flushes
    wc_base = word_count;
    wr_base = writes;
    done = 1'b0;
    fork
      begin
        repeat (200) beat(IN_W'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0), 1'b0);
        done = 1'b1;
      end
      begin
        while (!done) begin
          fifo_full = ($urandom_range(0, 2) == 0);
          @(posedge wr_clk);
          #1;
        end
      end
    join
    fifo_full = 1'b0;
    n = 0;
    while ((exp_q.size() != 0 || fifo_wr_en) && n < 50) begin
      cyc(1);
      n++;
    end
    check("t6_queue_drained", 32'(exp_q.size()), 32'd0);
    check("t6_count", 32'(word_count), 32'(CW'(wc_base + CW'(writes - wr_base))));
    check("t6_some_writes", 32'(writes - wr_base > 50), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_wr_packer.md
Name: fifo_wr_packer

Overview:
Write-domain front end for the async FIFO. Packs a narrow valid/ready input stream of IN_WIDTH-bit beats into DATA_WIDTH-bit words. Drives the FIFO's wr_en/data_in pair and obeys its full flag, so no word is ever dropped. Lives entirely in the wr_clk domain; s_last flushes a partially filled word.

Parameters:
IN_WIDTH, 4, width of one input beat in bits
DATA_WIDTH, 8, FIFO word width; must equal RATIO*IN_WIDTH, with integer RATIO >= 2
PAD_VALUE, 0, IN_WIDTH-bit value written into unfilled lanes on an s_last flush
CNT_WIDTH, 16, width of word_count

Ports:
wr_clk  input  1  write-domain clock; all state updates on its rising edge
rst  input  1  asynchronous, active-high reset
s_valid  input  1  input beat valid
s_ready  output  1  block can accept a beat this cycle
s_data  input  IN_WIDTH  input beat
s_last  input  1  beat closes the current word early (flush)
fifo_full  input  1  FIFO full flag (registered in the FIFO, wr_clk domain)
fifo_wr_en  output  1  write strobe to the FIFO
fifo_data  output  DATA_WIDTH  word to the FIFO data_in
word_count  output  CNT_WIDTH  total words written to the FIFO; wraps modulo 2^CNT_WIDTH
busy  output  1  partial word in progress or a word is held

Behaviour:
- Reset is rst, asynchronous and active-high; the clock is wr_clk. On reset:
  - acc = 0, lane = 0, out_valid = 0, fifo_data = 0, word_count = 0.
  - Outputs are therefore fifo_wr_en = 0, busy = 0, and s_ready = 1 once rst deasserts.
- Datapath:
  - acc is a DATA_WIDTH accumulator; lane counts 0..RATIO-1.
  - The out register (fifo_data) and its out_valid flag hold one complete word.
- Accept: a beat is taken when s_valid && s_ready.
  - s_data is written to acc lane `lane`, bits [lane*IN_WIDTH +: IN_WIDTH], little-endian: the first beat lands in the LSBs.
- Completion: an accepted beat completes the word when lane == RATIO-1 or s_last = 1.
  - The completed word moves to the out register: lanes 0..lane-1 come from acc, lane `lane` from s_data, and higher lanes are filled with PAD_VALUE.
  - out_valid is set, acc is cleared and lane returns to 0.
- Non-completing accept: lane increments by 1 and out_valid is unaffected.
- fifo_wr_en = out_valid && !fifo_full. This is combinational and is never asserted while fifo_full = 1.
- When fifo_wr_en = 1 at an edge:
  - word_count increments by 1.
  - out_valid clears, unless a completing beat is accepted in the same cycle; then the out register reloads with the new word and out_valid stays 1.
- s_ready = !out_valid || !fifo_full. This allows full throughput: one beat per cycle and one word per RATIO cycles.
- Latency: a word completed at edge N shows fifo_wr_en = 1 in the cycle after edge N, provided fifo_full = 0. The FIFO samples it at edge N+1.
- Backpressure: while out_valid && fifo_full:
  - s_ready = 0.
  - fifo_data, acc and lane hold stable.
  - Nothing is accepted or lost.
- The instant fifo_full drops, fifo_wr_en rises in the same cycle.
- s_last on lane RATIO-1 behaves as a normal completion; no extra padding word is produced.
- s_valid = 0 with a partial word: the partial word is held indefinitely. There is no timeout flush.
- busy = (lane != 0) || out_valid.
- Reset mid-operation discards the partial and held words. Nothing is written to the FIFO afterwards until new beats complete a word.
- Word order into the FIFO equals completion order.

Test Plan:
1. IN_WIDTH=4, DATA_WIDTH=8, fifo_full=0; beats 0xA then 0xB -> the cycle after beat 2: fifo_wr_en=1, fifo_data=0xBA; word_count 0->1.
2. Single beat 0x5 with s_last=1, PAD_VALUE=0 -> fifo_data=0x05, one wr_en pulse; lane back to 0; busy=0 after the write.
3. Word pending while fifo_full=1 held 5 cycles -> fifo_wr_en=0 and s_ready=0 throughout; fifo_data stable; fifo_full->0 gives wr_en=1 that same cycle, then word_count+1.
4. Continuous s_valid, 8 beats 0x1..0x8, fifo_full=0 -> s_ready constantly 1; words 0x21, 0x43, 0x65, 0x87 in order, one every 2 cycles; word_count=4.
5. Accept beat 0x3, assert rst mid-word, release, then beats 0x1, 0x2 -> only one word 0x21 is written; word_count=1; no stale 0x3.
6. Random fifo_full toggling with 200 random beats and random s_last -> the scoreboard sequence of FIFO words exactly matches the packed input; wr_en is never high with fifo_full=1.
